// File: rtl/uart_frame_assembler_if.sv
// Byte-stream in / frame-word out bundle for the UART frame assembler.
// master drives received bytes; slave assembles and returns frames.
interface uart_frame_assembler_if #(
  parameter int NUM_BYTES = 2
);
  logic [7:0]             rx_data;
  logic                   rx_done;
  logic                   rx_parity_error;
  logic [8*NUM_BYTES-1:0] frame_data;
  logic                   frame_valid;

  modport master (
    output rx_data,
    output rx_done,
    output rx_parity_error,
    input  frame_data,
    input  frame_valid
  );

  modport slave (
    input  rx_data,
    input  rx_done,
    input  rx_parity_error,
    output frame_data,
    output frame_valid
  );
endinterface

// File: rtl/uart_frame_assembler.sv
// Packs uart_rx bytes into NUM_BYTES-wide command words, first byte in the MSBs.
// Drops partial frames on parity error, inter-byte timeout or enable low.
module uart_frame_assembler #(
  parameter int NUM_BYTES      = 2,
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int QUIET_CYCLES   = 48000,
  parameter int CNT_W          = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  uart_frame_assembler_if.slave            bus,
  output logic                             busy,
  output logic [$clog2(NUM_BYTES+1)-1:0]   byte_idx,
  output logic                             parity_err_pulse,
  output logic                             timeout_pulse,
  output logic [7:0]                       err_count
);
  localparam int W  = 8 * NUM_BYTES;
  localparam int IW = $clog2(NUM_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESYNC  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     buf_q, buf_d;
  logic [W-1:0]     frame_q, frame_d;
  logic             fv_q, fv_d;
  logic             pe_q, pe_d;
  logic             to_q, to_d;
  logic [7:0]       err_q;

  logic         good;
  logic         bad;
  logic         last;
  logic         tmo;
  logic         quiet;
  logic [W-1:0] byte_w;
  logic [W-1:0] shifted;

  assign good    = bus.rx_done & ~bus.rx_parity_error;
  assign bad     = bus.rx_done & bus.rx_parity_error;
  assign last    = idx_q == IW'(NUM_BYTES - 1);
  assign tmo     = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  assign quiet   = cnt_q == CNT_W'(QUIET_CYCLES - 1);
  assign byte_w  = W'(bus.rx_data);
  assign shifted = (buf_q << 8) | byte_w;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Timeout outranks a byte landing on the same cycle.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bad)                        state_d = RESYNC;
          else if (good && NUM_BYTES > 1) state_d = COLLECT;
        end
        COLLECT: begin
          if (tmo)               state_d = IDLE;
          else if (bad)          state_d = RESYNC;
          else if (good && last) state_d = IDLE;
        end
        RESYNC: begin
          if (!bus.rx_done && quiet) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    idx_d   = '0;
    cnt_d   = '0;
    buf_d   = buf_q;
    frame_d = frame_q;
    fv_d    = 1'b0;
    pe_d    = 1'b0;
    to_d    = 1'b0;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (bad) begin
            pe_d = 1'b1;
          end else if (good) begin
            if (NUM_BYTES == 1) begin
              frame_d = byte_w;
              fv_d    = 1'b1;
            end else begin
              buf_d = byte_w;
              idx_d = IW'(1);
            end
          end
        end
        COLLECT: begin
          if (tmo) begin
            to_d = 1'b1;
          end else if (bad) begin
            pe_d = 1'b1;
          end else if (good) begin
            if (last) begin
              frame_d = shifted;
              fv_d    = 1'b1;
            end else begin
              buf_d = shifted;
              idx_d = idx_q + IW'(1);
            end
          end else begin
            idx_d = idx_q;
            cnt_d = cnt_q + 1'b1;
          end
        end
        RESYNC: begin
          if (!bus.rx_done && !quiet) cnt_d = cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      frame_q <= '0;
      fv_q    <= 1'b0;
      pe_q    <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
      pe_q    <= pe_d;
      to_q    <= to_d;
      if ((pe_d || to_d) && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  assign bus.frame_data  = frame_q;
  assign bus.frame_valid = fv_q;
  assign busy             = state_q != IDLE;
  assign byte_idx         = idx_q;
  assign parity_err_pulse = pe_q;
  assign timeout_pulse    = to_q;
  assign err_count        = err_q;
endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler: 2-, 3- and 1-byte builds
// with short timers, plus a default-parameter build for exact timeout.
module tb_uart_frame_assembler;
  localparam int T = 40;
  localparam int Q = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       rx_pe = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_frame_assembler_if #(.NUM_BYTES(2)) i2 ();
  uart_frame_assembler_if #(.NUM_BYTES(3)) i3 ();
  uart_frame_assembler_if #(.NUM_BYTES(1)) i1 ();
  uart_frame_assembler_if #(.NUM_BYTES(2)) id ();

  assign i2.rx_data = rx_data;
  assign i2.rx_done = rx_done;
  assign i2.rx_parity_error = rx_pe;
  assign i3.rx_data = rx_data;
  assign i3.rx_done = rx_done;
  assign i3.rx_parity_error = rx_pe;
  assign i1.rx_data = rx_data;
  assign i1.rx_done = rx_done;
  assign i1.rx_parity_error = rx_pe;
  assign id.rx_data = rx_data;
  assign id.rx_done = rx_done;
  assign id.rx_parity_error = rx_pe;

  logic       busy2, pe2, to2;
  logic [1:0] idx2;
  logic [7:0] err2;
  logic       busy3, pe3, to3;
  logic [1:0] idx3;
  logic [7:0] err3;
  logic       busy1, pe1, to1;
  logic [0:0] idx1;
  logic [7:0] err1;
  logic       busyd, ped, tod;
  logic [1:0] idxd;
  logic [7:0] errd;

  uart_frame_assembler #(
    .NUM_BYTES(2), .TIMEOUT_CYCLES(T), .QUIET_CYCLES(Q), .CNT_W(16)
  ) d2 (
    .clk(clk), .reset(reset), .enable(enable), .bus(i2.slave),
    .busy(busy2), .byte_idx(idx2), .parity_err_pulse(pe2),
    .timeout_pulse(to2), .err_count(err2)
  );

  uart_frame_assembler #(
    .NUM_BYTES(3), .TIMEOUT_CYCLES(T), .QUIET_CYCLES(Q), .CNT_W(16)
  ) d3 (
    .clk(clk), .reset(reset), .enable(enable), .bus(i3.slave),
    .busy(busy3), .byte_idx(idx3), .parity_err_pulse(pe3),
    .timeout_pulse(to3), .err_count(err3)
  );

  uart_frame_assembler #(
    .NUM_BYTES(1), .TIMEOUT_CYCLES(T), .QUIET_CYCLES(Q), .CNT_W(16)
  ) d1 (
    .clk(clk), .reset(reset), .enable(enable), .bus(i1.slave),
    .busy(busy1), .byte_idx(idx1), .parity_err_pulse(pe1),
    .timeout_pulse(to1), .err_count(err1)
  );

  uart_frame_assembler dd (
    .clk(clk), .reset(reset), .enable(enable), .bus(id.slave),
    .busy(busyd), .byte_idx(idxd), .parity_err_pulse(ped),
    .timeout_pulse(tod), .err_count(errd)
  );

  typedef struct {
    logic [7:0]  b;
    logic        pe;
    int          gap;
    logic [15:0] frame;
    logic        fv;
    logic        pep;
    logic        busy;
    logic [1:0]  idx;
    logic [7:0]  err;
  } vec_t;

  vec_t vec [11];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic pe);
    rx_data = b;
    rx_pe   = pe;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_pe   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  initial begin
    int n;
    int pulses;
    vec[0]  = '{8'h0A, 1'b0, 3,  16'h0000, 1'b0, 1'b0, 1'b1, 2'd1, 8'd0};
    vec[1]  = '{8'hBC, 1'b0, 5,  16'h0ABC, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    vec[2]  = '{8'h12, 1'b0, 2,  16'h0ABC, 1'b0, 1'b0, 1'b1, 2'd1, 8'd0};
    vec[3]  = '{8'hEE, 1'b1, 2,  16'h0ABC, 1'b0, 1'b1, 1'b1, 2'd0, 8'd1};
    vec[4]  = '{8'h34, 1'b0, 2,  16'h0ABC, 1'b0, 1'b0, 1'b1, 2'd0, 8'd1};
    vec[5]  = '{8'h56, 1'b0, 70, 16'h0ABC, 1'b0, 1'b0, 1'b1, 2'd0, 8'd1};
    vec[6]  = '{8'h34, 1'b0, 2,  16'h0ABC, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1};
    vec[7]  = '{8'h56, 1'b0, 2,  16'h3456, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};
    vec[8]  = '{8'h99, 1'b1, 65, 16'h3456, 1'b0, 1'b1, 1'b1, 2'd0, 8'd2};
    vec[9]  = '{8'h01, 1'b0, 1,  16'h3456, 1'b0, 1'b0, 1'b1, 2'd1, 8'd2};
    vec[10] = '{8'h02, 1'b0, 1,  16'h0102, 1'b1, 1'b0, 1'b0, 2'd0, 8'd2};

    // reset with enable high
    idle(2);
    check("rst frame", 32'(i2.frame_data), 32'h0);
    check("rst valid", 32'(i2.frame_valid), 32'h0);
    check("rst busy", 32'(busy2), 32'h0);
    check("rst idx", 32'(idx2), 32'h0);
    check("rst pe", 32'(pe2), 32'h0);
    check("rst to", 32'(to2), 32'h0);
    check("rst err", 32'(err2), 32'h0);
    reset = 1'b0;
    idle(1);

    // default build: timeout lands exactly 24000 cycles after the byte
    send(8'h12, 1'b0);
    check("dflt idx1", 32'(idxd), 32'h1);
    n = 0;
    while (n < 30000 && tod !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("dflt tmo cycle", 32'(n), 32'd24000);
    check("dflt tmo idx", 32'(idxd), 32'h0);
    check("dflt tmo busy", 32'(busyd), 32'h0);
    check("dflt tmo err", 32'(errd), 32'h1);
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    check("dflt 7788", 32'(id.frame_data), 32'h7788);
    check("dflt 7788 v", 32'(id.frame_valid), 32'h1);

    // 3-byte and 1-byte builds
    do_reset();
    send(8'h01, 1'b0);
    check("n1 01 v", 32'(i1.frame_valid), 32'h1);
    check("n1 01", 32'(i1.frame_data), 32'h01);
    check("n3 idx1", 32'(idx3), 32'h1);
    send(8'h02, 1'b0);
    check("n3 idx2", 32'(idx3), 32'h2);
    check("n3 v0", 32'(i3.frame_valid), 32'h0);
    send(8'h03, 1'b0);
    check("n3 frame", 32'(i3.frame_data), 32'h010203);
    check("n3 v", 32'(i3.frame_valid), 32'h1);
    check("n3 idx0", 32'(idx3), 32'h0);
    send(8'h5A, 1'b0);
    check("n1 5A", 32'(i1.frame_data), 32'h5A);
    check("n1 5A v", 32'(i1.frame_valid), 32'h1);
    check("n3 hold", 32'(i3.frame_data), 32'h010203);
    check("n3 v off", 32'(i3.frame_valid), 32'h0);

    // table: good frames, parity discard, resync
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send(vec[i].b, vec[i].pe);
      check($sformatf("v%0d frame", i), 32'(i2.frame_data), 32'(vec[i].frame));
      check($sformatf("v%0d valid", i), 32'(i2.frame_valid), 32'(vec[i].fv));
      check($sformatf("v%0d pe", i), 32'(pe2), 32'(vec[i].pep));
      check($sformatf("v%0d busy", i), 32'(busy2), 32'(vec[i].busy));
      check($sformatf("v%0d idx", i), 32'(idx2), 32'(vec[i].idx));
      check($sformatf("v%0d err", i), 32'(err2), 32'(vec[i].err));
      idle(vec[i].gap);
    end
    check("valid width", 32'(i2.frame_valid), 32'h0);

    // timeout boundary
    send(8'h12, 1'b0);
    idle(T - 1);
    check("pre tmo", 32'(to2), 32'h0);
    check("pre tmo busy", 32'(busy2), 32'h1);
    idle(1);
    check("tmo", 32'(to2), 32'h1);
    check("tmo busy", 32'(busy2), 32'h0);
    check("tmo idx", 32'(idx2), 32'h0);
    check("tmo err", 32'(err2), 32'd3);
    idle(1);
    check("tmo width", 32'(to2), 32'h0);

    // byte on the timeout cycle is dropped
    send(8'h12, 1'b0);
    idle(T - 1);
    send(8'h55, 1'b0);
    check("tie tmo", 32'(to2), 32'h1);
    check("tie valid", 32'(i2.frame_valid), 32'h0);
    check("tie busy", 32'(busy2), 32'h0);
    check("tie err", 32'(err2), 32'd4);
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    check("7788", 32'(i2.frame_data), 32'h7788);

    // a byte inside RESYNC restarts the quiet window
    send(8'hEE, 1'b1);
    check("rs pe", 32'(pe2), 32'h1);
    check("rs err", 32'(err2), 32'd5);
    idle(Q - 10);
    send(8'h11, 1'b0);
    idle(Q - 1);
    check("rs still", 32'(busy2), 32'h1);
    idle(1);
    check("rs exit", 32'(busy2), 32'h0);
    check("rs frame", 32'(i2.frame_data), 32'h7788);

    // enable low drops the partial frame silently
    send(8'h21, 1'b0);
    enable = 1'b0;
    idle(1);
    check("en busy", 32'(busy2), 32'h0);
    check("en idx", 32'(idx2), 32'h0);
    send(8'h22, 1'b0);
    send(8'h23, 1'b0);
    check("en valid", 32'(i2.frame_valid), 32'h0);
    idle(T + 5);
    check("en frame", 32'(i2.frame_data), 32'h7788);
    check("en err", 32'(err2), 32'd5);
    enable = 1'b1;
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    check("en 3132", 32'(i2.frame_data), 32'h3132);

    // error counter saturation
    pulses = 0;
    for (int i = 0; i < 260; i++) begin
      send(8'h40, 1'b0);
      idle(T);
      if (to2 === 1'b1) pulses++;
    end
    check("sat pulses", 32'(pulses), 32'd260);
    check("sat err", 32'(err2), 32'd255);

    // reset mid-frame
    send(8'h66, 1'b0);
    reset = 1'b1;
    idle(1);
    check("mrst frame", 32'(i2.frame_data), 32'h0);
    check("mrst busy", 32'(busy2), 32'h0);
    check("mrst idx", 32'(idx2), 32'h0);
    check("mrst err", 32'(err2), 32'h0);
    check("mrst pe", 32'(pe2), 32'h0);
    check("mrst to", 32'(to2), 32'h0);
    reset = 1'b0;
    idle(3);
    check("mrst valid", 32'(i2.frame_valid), 32'h0);
    check("mrst frame2", 32'(i2.frame_data), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
